// File: rtl/mac_pkg.sv
// Shared defaults and helpers for the multichannel multiply-accumulate array.
package mac_pkg;

  localparam int MAC_DATA_W   = 4;
  localparam int MAC_ACC_W    = 10;
  localparam int MAC_CHANNELS = 2;

  localparam int MAC_WRAP = 0;
  localparam int MAC_SAT  = 1;

  // Ceiling log2; returns 0 for n <= 1, so callers clamp to a 1-bit minimum.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One accumulator channel: wrap/saturate adder plus sticky overflow flag.
module mac_acc_lane
  import mac_pkg::*;
#(
  parameter int ACC_W    = MAC_ACC_W,
  parameter int SATURATE = MAC_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [ACC_W-1:0] p,
  output logic [ACC_W-1:0] acc,
  output logic             overflow
);

  logic [ACC_W-1:0] acc_reg;
  logic             ovf_reg;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;

  // One extra bit of sum width exposes the carry that signals overflow.
  always_comb begin
    sum      = {1'b0, (clear ? {ACC_W{1'b0}} : acc_reg)} + {1'b0, p};
    acc_next = sum[ACC_W-1:0];
    if (sum[ACC_W] && (SATURATE == MAC_SAT)) acc_next = {ACC_W{1'b1}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (en) begin
      acc_reg <= acc_next;
      ovf_reg <= clear ? 1'b0 : (ovf_reg | sum[ACC_W]);
    end
  end

  assign acc      = acc_reg;
  assign overflow = ovf_reg;

endmodule

// File: rtl/multichannel_mac.sv
// Pipelined MAC array: shared multiplier stage feeding per-channel accumulator lanes.
module multichannel_mac
  import mac_pkg::*;
#(
  parameter int DATA_W   = MAC_DATA_W,
  parameter int ACC_W    = MAC_ACC_W,
  parameter int CHANNELS = MAC_CHANNELS,
  parameter int SATURATE = MAC_WRAP,
  localparam int CH_W    = (clog2(CHANNELS) > 1) ? clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         in_a,
  input  logic [DATA_W-1:0]         in_b,
  input  logic [CH_W-1:0]           in_chan,
  input  logic                      in_clear,
  output logic [CHANNELS*ACC_W-1:0] acc_out,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_chan,
  output logic [CHANNELS-1:0]       overflow
);

  logic [2*DATA_W-1:0] prod;
  logic                in_range;
  logic                accept;

  logic [ACC_W-1:0]    p1_reg;
  logic [CH_W-1:0]     chan1_reg;
  logic                clear1_reg;
  logic                v1_reg;
  logic                out_valid_reg;
  logic [CH_W-1:0]     out_chan_reg;

  assign prod     = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
  assign in_range = ({{(32-CH_W){1'b0}}, in_chan} < 32'(CHANNELS));
  assign accept   = in_valid && in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p1_reg     <= '0;
      chan1_reg  <= '0;
      clear1_reg <= 1'b0;
      v1_reg     <= 1'b0;
    end else begin
      v1_reg <= accept;
      if (accept) begin
        p1_reg     <= ACC_W'(prod);
        chan1_reg  <= in_chan;
        clear1_reg <= in_clear;
      end
    end
  end

  // out_chan keeps the last updated channel between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
    end else begin
      out_valid_reg <= v1_reg;
      if (v1_reg) out_chan_reg <= chan1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic lane_en;
      assign lane_en = v1_reg && (chan1_reg == CH_W'(gi));

      mac_acc_lane #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
      ) u_lane (
        .clk      (clk),
        .reset    (reset),
        .en       (lane_en),
        .clear    (clear1_reg),
        .p        (p1_reg),
        .acc      (acc_out[gi*ACC_W +: ACC_W]),
        .overflow (overflow[gi])
      );
    end
  endgenerate

  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;

endmodule
